// File: rtl/mem_rw_arbiter.sv
// Two-client round-robin arbiter in front of mem_rw_controller: grants one
// read/write burst at a time, routes data/handshakes, aborts on a missing ack.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a client request; grant and latch request here
// REQ    | controller request held high until ack or ack timeout
// XFER   | data/handshake pass-through for the granted client
// DONE   | one-cycle wrap-up: zero-length ack or timeout err pulse
module mem_rw_arbiter #(
  parameter int ADDR_W      = 6,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [1:0]          i_req,
  input  logic [1:0]          i_we,
  input  logic [2*ADDR_W-1:0] i_addr,
  input  logic [7:0]          i_num_b,
  input  logic [15:0]         i_wr_data,
  input  logic [1:0]          i_wr_valid,
  output logic [1:0]          o_wr_done,
  output logic [7:0]          o_rd_data,
  output logic [1:0]          o_rd_valid,
  input  logic [1:0]          i_rd_done,
  output logic [1:0]          o_ack,
  output logic [1:0]          o_err,
  output logic                o_m_wr_req,
  output logic [7:0]          o_m_wr_data,
  output logic                o_m_wr_valid,
  input  logic                i_m_wr_done,
  output logic                o_m_rd_req,
  input  logic [7:0]          i_m_rd_data,
  input  logic                i_m_rd_valid,
  output logic                o_m_rd_done,
  output logic [ADDR_W-1:0]   o_m_addr,
  output logic [3:0]          o_m_num_b,
  input  logic                i_m_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        g;
  logic        last_grant;
  logic        gnt_sel;
  logic        we_q;
  logic        zero_len;
  logic        timed_out;
  logic [7:0]  t_cnt;
  logic [3:0]  b_cnt;
  logic        byte_ev;
  logic        ack_to;
  logic [3:0]  sel_num_b;
  logic [ADDR_W-1:0] sel_addr;

  // Both requesting: the client that was not served last wins.
  always_comb begin
    gnt_sel = 1'b0;
    if (i_req == 2'b11)
      gnt_sel = ~last_grant;
    else if (i_req[1])
      gnt_sel = 1'b1;
  end

  assign sel_num_b = gnt_sel ? i_num_b[7:4] : i_num_b[3:0];
  assign sel_addr  = gnt_sel ? i_addr[2*ADDR_W-1:ADDR_W] : i_addr[ADDR_W-1:0];
  assign byte_ev   = we_q ? i_m_wr_done : (i_m_rd_valid & (g ? i_rd_done[1] : i_rd_done[0]));
  assign ack_to    = (t_cnt == TO_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_ack        = 2'b00;
    o_err        = 2'b00;
    o_m_wr_req   = 1'b0;
    o_m_rd_req   = 1'b0;
    o_m_wr_data  = 8'h00;
    o_m_wr_valid = 1'b0;
    o_wr_done    = 2'b00;
    o_rd_data    = 8'h00;
    o_rd_valid   = 2'b00;
    o_m_rd_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (|i_req)
          state_nxt = (sel_num_b == 4'd0) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        o_m_wr_req = we_q;
        o_m_rd_req = ~we_q;
        if (i_m_ack) begin
          o_ack[g]  = 1'b1;
          state_nxt = S_XFER;
        end else if (ack_to) begin
          state_nxt = S_DONE;
        end
      end
      S_XFER: begin
        if (we_q) begin
          o_m_wr_data  = g ? i_wr_data[15:8] : i_wr_data[7:0];
          o_m_wr_valid = g ? i_wr_valid[1] : i_wr_valid[0];
          o_wr_done[g] = i_m_wr_done;
        end else begin
          o_rd_data     = i_m_rd_data;
          o_rd_valid[g] = i_m_rd_valid;
          o_m_rd_done   = g ? i_rd_done[1] : i_rd_done[0];
        end
        if (byte_ev && ((b_cnt + 4'd1) == o_m_num_b))
          state_nxt = S_DONE;
      end
      S_DONE: begin
        o_ack[g]  = zero_len;
        o_err[g]  = timed_out;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      g          <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      zero_len   <= 1'b0;
      timed_out  <= 1'b0;
      t_cnt      <= 8'd0;
      b_cnt      <= 4'd0;
      o_m_addr   <= '0;
      o_m_num_b  <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|i_req) begin
            g         <= gnt_sel;
            we_q      <= i_we[gnt_sel];
            o_m_addr  <= sel_addr;
            o_m_num_b <= sel_num_b;
            zero_len  <= (sel_num_b == 4'd0);
          end
        end
        S_REQ: begin
          if (i_m_ack) begin
            t_cnt <= 8'd0;
          end else if (ack_to) begin
            timed_out <= 1'b1;
            t_cnt     <= 8'd0;
          end else begin
            t_cnt <= t_cnt + 8'd1;
          end
        end
        S_XFER: begin
          if (byte_ev)
            b_cnt <= b_cnt + 4'd1;
        end
        S_DONE: begin
          last_grant <= g;
          t_cnt      <= 8'd0;
          b_cnt      <= 4'd0;
          zero_len   <= 1'b0;
          timed_out  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
